// File: rtl/fir_out_requant.sv
// fir_out_requant: downstream requantizer for the parallel FIR accumulator.
// Stage 1 adds half an LSB and arithmetically shifts away SHIFT fraction
// bits, which rounds half-up toward +inf. Stage 2 clamps the result to the
// signed output range and flags any clipping. The two registers form an
// elastic valid/ready pipeline that holds up to two samples.
// Optional feature macro: FIR_REQUANT_SATCNT_EN adds sat_clr/sat_count, a
// 16-bit saturating count of delivered samples that were clipped.
module fir_out_requant #(
  parameter int DATA_IN_WIDTH  = 64,
  parameter int DATA_OUT_WIDTH = 16,
  parameter int SHIFT          = 30
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_IN_WIDTH-1:0]  in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_OUT_WIDTH-1:0] out_data,
  output logic                      out_sat
`ifdef FIR_REQUANT_SATCNT_EN
  ,
  input  logic                      sat_clr,
  output logic [15:0]               sat_count
`endif
);

  // One guard bit above the input keeps the rounding addition from
  // overflowing when the input is at its positive maximum.
  localparam int QW = DATA_IN_WIDTH + 1;

  localparam int             RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [QW-1:0]  Q_ONE   = {{(QW-1){1'b0}}, 1'b1};
  localparam logic [QW-1:0]  RND_ADD = (SHIFT > 0) ? (Q_ONE << RND_POS) : {QW{1'b0}};
  localparam logic [QW-1:0]  MAX_Q   = (Q_ONE << (DATA_OUT_WIDTH - 1)) - Q_ONE;
  localparam logic [QW-1:0]  MIN_Q   = ~MAX_Q;

  // Clamp a rounded value to the output range; MSB of the result is the
  // clip flag, the remaining bits are the output sample.
  function automatic logic [DATA_OUT_WIDTH:0] saturate(input logic signed [QW-1:0] q);
    logic [DATA_OUT_WIDTH:0] res;
    if (q > $signed(MAX_Q)) begin
      res = {1'b1, MAX_Q[DATA_OUT_WIDTH-1:0]};
    end else if (q < $signed(MIN_Q)) begin
      res = {1'b1, MIN_Q[DATA_OUT_WIDTH-1:0]};
    end else begin
      res = {1'b0, q[DATA_OUT_WIDTH-1:0]};
    end
    return res;
  endfunction

  logic                      s1_valid_r;
  logic signed [QW-1:0]      s1_q_r;
  logic                      s2_valid_r;
  logic [DATA_OUT_WIDTH-1:0] s2_data_r;
  logic                      s2_sat_r;

  logic                      s1_adv_s;
  logic                      s2_adv_s;
  logic signed [QW-1:0]      ext_s;
  logic signed [QW-1:0]      sum_s;
  logic signed [QW-1:0]      q_s;
  logic [DATA_OUT_WIDTH:0]   sat_res_s;

  // Advance enables: a stage may load when it is empty or its content leaves.
  always_comb begin
    s2_adv_s = !s2_valid_r || out_ready;
    s1_adv_s = !s1_valid_r || s2_adv_s;
  end

  // Round half-up: sign-extend, add half an output LSB, arithmetic shift.
  always_comb begin
    ext_s = $signed({in_data[DATA_IN_WIDTH-1], in_data});
    sum_s = ext_s + $signed(RND_ADD);
    q_s   = sum_s >>> SHIFT;
  end

  // Saturation of the stage-1 value feeding the output register.
  always_comb begin
    sat_res_s = saturate(s1_q_r);
  end

  // Stage 1 register: captures the rounded sample whenever it may advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0;
      s1_q_r     <= {QW{1'b0}};
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_q_r <= q_s;
      end else begin
        s1_q_r <= s1_q_r;
      end
    end else begin
      s1_valid_r <= s1_valid_r;
      s1_q_r     <= s1_q_r;
    end
  end

  // Stage 2 register: holds the clamped output stable while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_r <= 1'b0;
      s2_data_r  <= {DATA_OUT_WIDTH{1'b0}};
      s2_sat_r   <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_data_r <= sat_res_s[DATA_OUT_WIDTH-1:0];
        s2_sat_r  <= sat_res_s[DATA_OUT_WIDTH];
      end else begin
        s2_data_r <= s2_data_r;
        s2_sat_r  <= s2_sat_r;
      end
    end else begin
      s2_valid_r <= s2_valid_r;
      s2_data_r  <= s2_data_r;
      s2_sat_r   <= s2_sat_r;
    end
  end

  assign in_ready  = s1_adv_s;
  assign out_valid = s2_valid_r;
  assign out_data  = s2_data_r;
  assign out_sat   = s2_sat_r;

`ifdef FIR_REQUANT_SATCNT_EN
  logic [15:0] sat_count_r;

  // Count delivered clipped samples; clear wins, count sticks at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_count_r <= 16'd0;
    end else if (sat_clr) begin
      sat_count_r <= 16'd0;
    end else if (s2_valid_r && out_ready && s2_sat_r && (sat_count_r != 16'hFFFF)) begin
      sat_count_r <= sat_count_r + 16'd1;
    end else begin
      sat_count_r <= sat_count_r;
    end
  end

  assign sat_count = sat_count_r;
`endif

endmodule

// File: tb/tb_fir_out_requant.sv
// Bench for fir_out_requant: directed literal cases, latency/throughput,
// backpressure, mid-operation reset and a randomized phase, all scored by
// a plain-arithmetic reference model through a FIFO scoreboard.
module tb_fir_out_requant;
  localparam int IW = 64;
  localparam int OW = 16;
  localparam int SH = 30;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_sat;
  logic [OW-1:0] out_data;
`ifdef FIR_REQUANT_SATCNT_EN
  logic          sat_clr = 1'b0;
  logic [15:0]   sat_count;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int out_cnt = 0;
  int exp_cnt = 0;
  logic [OW:0] exp_q[$];
  int acc_cyc[$];
  int out_cyc[$];
  logic held_valid = 1'b0;
  logic [OW:0] held_val = '0;
  logic [OW:0] last_out = '0;

  fir_out_requant #(.DATA_IN_WIDTH(IW), .DATA_OUT_WIDTH(OW), .SHIFT(SH)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
`ifdef FIR_REQUANT_SATCNT_EN
    , .sat_clr(sat_clr), .sat_count(sat_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact floor((x + 2^(SH-1)) / 2^SH) in wide arithmetic, then clamp.
  function automatic logic [OW:0] model(input logic [IW-1:0] x);
    logic signed [127:0] v, d, q;
    v = $signed(x);
    d = 128'sd1 <<< SH;
    v = v + (128'sd1 <<< (SH - 1));
    q = v / d;
    if (v < 0 && (v % d) != 0) q = q - 128'sd1;
    if (q > 128'sd32767) return {1'b1, 16'h7FFF};
    else if (q < -128'sd32768) return {1'b1, 16'h8000};
    else return {1'b0, q[OW-1:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int n0, input string name);
    int t = 0;
    while (out_cnt <= n0 && t < 20) begin
      tick();
      t++;
    end
    if (out_cnt <= n0) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout got no output expected one", name);
    end
  endtask

  task automatic send_lit(input string name, input logic [IW-1:0] x, input logic [OW:0] exp);
    int n0;
    chk({"model_", name}, model(x), exp);
    n0 = out_cnt;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = x;
    tick();
    in_valid = 1'b0;
    wait_out(n0, name);
    chk(name, last_out, exp);
  endtask

  function automatic logic [IW-1:0] rand_in();
    longint k;
    logic [IW-1:0] r;
    case ($urandom_range(0, 3))
      0: r = {$urandom, $urandom};
      1: begin
        k = longint'($urandom_range(0, 80000)) - 40000;
        r = 64'(k <<< 30) + 64'($urandom_range(0, 32'h3FFFFFFF));
      end
      2: begin
        k = longint'($urandom_range(0, 80000)) - 40000;
        r = 64'(k <<< 30) + (64'd1 << 29) - 64'($urandom_range(0, 1));
      end
      default: begin
        k = ($urandom_range(0, 1) == 0) ? longint'(32767) : longint'(-32769);
        r = 64'(k <<< 30) + 64'($urandom_range(0, 32'h7FFFFFFF));
      end
    endcase
    return r;
  endfunction

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      held_valid = 1'b0;
      exp_cnt = 0;
    end else begin
`ifdef FIR_REQUANT_SATCNT_EN
      chk("sat_count", sat_count, exp_cnt);
`endif
      if (held_valid) chk("hold", {out_valid, out_sat, out_data}, {1'b1, held_val});
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data));
        acc_cyc.push_back(cyc);
      end
      if (out_valid && exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL stale: got out_valid=1 data=%h expected no output", out_data);
      end else if (out_valid && out_ready) begin
        chk("out", {out_sat, out_data}, exp_q.pop_front());
      end
      if (out_valid && out_ready) begin
        out_cyc.push_back(cyc);
        out_cnt++;
        last_out = {out_sat, out_data};
      end
      held_valid = out_valid && !out_ready;
      held_val = {out_sat, out_data};
`ifdef FIR_REQUANT_SATCNT_EN
      if (sat_clr) exp_cnt = 0;
      else if (out_valid && out_ready && out_sat && exp_cnt < 65535) exp_cnt++;
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int t;
    logic [IW-1:0] vals[4];
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sat", out_sat, 0);
    reset_n = 1'b1;
    tick();

    // Directed rounding and saturation literals.
    send_lit("r3",     64'd3 << 30, {1'b0, 16'd3});
    send_lit("r3p5",   (64'd3 << 30) + (64'd1 << 29), {1'b0, 16'd4});
    send_lit("rm3p5",  -(64'd3 << 30) - (64'd1 << 29), {1'b0, 16'hFFFD});
    send_lit("rmhalf", -(64'd1 << 29), {1'b0, 16'd0});
    send_lit("satp",   64'd40000 << 30, {1'b1, 16'h7FFF});
    send_lit("satn",   -(64'd40000 << 30), {1'b1, 16'h8000});
    send_lit("maxin",  64'h7FFF_FFFF_FFFF_FFFF, {1'b1, 16'h7FFF});
    send_lit("minin",  64'h8000_0000_0000_0000, {1'b1, 16'h8000});
    send_lit("edgep",  (64'd32767 << 30) + (64'd1 << 29), {1'b1, 16'h7FFF});
    send_lit("edgen",  -(64'd32768 << 30) - (64'd1 << 29), {1'b0, 16'h8000});

    // Latency and throughput.
    acc_cyc.delete();
    out_cyc.delete();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data = 64'(i) << 30;
      tick();
    end
    in_valid = 1'b0;
    repeat (5) tick();
    chk("acc_n", acc_cyc.size(), 8);
    chk("out_n", out_cyc.size(), 8);
    if (acc_cyc.size() == 8 && out_cyc.size() == 8) begin
      chk("latency", out_cyc[0] - acc_cyc[0], 2);
      chk("burst", out_cyc[7] - out_cyc[0], 7);
    end

    // Backpressure: only two samples fit while the output is stalled.
    for (int i = 0; i < 4; i++) vals[i] = 64'(i + 1) << 30;
    out_ready = 1'b0;
    idx = 0;
    repeat (4) begin
      in_valid = 1'b1;
      in_data = vals[idx];
      @(negedge clk);
      if (in_ready) idx++;
      tick();
    end
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    t = 0;
    while (idx < 4 && t < 20) begin
      in_valid = 1'b1;
      in_data = vals[idx];
      @(negedge clk);
      if (in_ready) idx++;
      tick();
      t++;
    end
    chk("bp_all_in", idx, 4);
    in_valid = 1'b0;
    repeat (5) tick();
    chk("bp_drained", exp_q.size(), 0);

    // Reset with both stages full.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 64'd5 << 30;
    tick();
    in_data = 64'd6 << 30;
    tick();
    in_valid = 1'b0;
    tick();
    chk("pre_rst_valid", out_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_sat", out_sat, 0);
    tick();
    tick();
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_valid", out_valid, 0);
    end
    tick();

`ifdef FIR_REQUANT_SATCNT_EN
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      in_valid = 1'b1;
      in_data = 64'd40000 << 30;
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    chk("satcnt3", sat_count, 3);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = -(64'd40000 << 30);
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("satcnt_clr", sat_count, 0);
    repeat (2) tick();
`endif

    // Randomized traffic.
    repeat (400) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = rand_in();
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef FIR_REQUANT_SATCNT_EN
      sat_clr = ($urandom_range(0, 31) == 0);
`endif
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
`ifdef FIR_REQUANT_SATCNT_EN
    sat_clr = 1'b0;
`endif
    repeat (5) tick();
    chk("rand_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
